// File: rtl/fpu_pkg.sv
// Shared FPU normalisation types and widths.
package fpu_pkg;

    localparam int unsigned MANT_W = 24;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned CODE_W = 3;
    localparam int unsigned SEL_W  = 1 << CODE_W;

    // All-ones biased exponent encodes Inf/NaN.
    localparam logic [EXP_W-1:0] EXP_MAX = {EXP_W{1'b1}};

    typedef struct packed {
        logic ovf;
        logic unf;
        logic zero;
    } norm_flags_t;

    typedef struct packed {
        logic [MANT_W:0]   mant;
        logic [EXP_W-1:0]  exp;
        logic [SEL_W-1:0]  sel;
        logic              carry;
        logic              zero;
    } norm_beat_t;

endpackage

// File: rtl/norm_code_decoder.sv
// Decodes a binary left-shift count into a one-hot shift select.
module norm_code_decoder
    import fpu_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [SEL_W-1:0]  sel
);

    // One-hot decode of the shift count.
    always_comb begin
        sel = '0;
        for (int i = 0; i < SEL_W; i++) begin
            sel[i] = (code == CODE_W'(i));
        end
    end

endmodule

// File: rtl/fpu_norm_shift_decoder.sv
// Two-stage normalise-shift pipeline: decode the shift code, then shift the
// mantissa and adjust the exponent with overflow/underflow clamping.
module fpu_norm_shift_decoder
    import fpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W:0]   in_mant,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [CODE_W-1:0] in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-1:0] out_mant,
    output logic [EXP_W-1:0]  out_exp,
    output logic [2:0]        out_flags
);

    logic [SEL_W-1:0] in_sel;
    logic             s1_valid;
    logic             s1_adv;
    logic             s2_adv;
    logic             accept;
    norm_beat_t       s1_beat;

    logic [CODE_W-1:0] shift_k;
    logic [EXP_W:0]    exp_ext;
    logic [EXP_W:0]    k_ext;
    logic [EXP_W:0]    exp_inc;
    logic [EXP_W:0]    exp_dec;
    logic [MANT_W-1:0] nx_mant;
    logic [EXP_W-1:0]  nx_exp;
    norm_flags_t       nx_flags;

    norm_code_decoder u_dec (
        .code (in_code),
        .sel  (in_sel)
    );

    // Handshake: each stage moves when the one below it can take data.
    always_comb begin
        s2_adv   = !out_valid || out_ready;
        s1_adv   = !s1_valid || s2_adv;
        in_ready = !flush && s1_adv;
        accept   = in_valid && in_ready;
    end

    // Stage 1: capture the beat with its decoded select and classification.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_beat  <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= accept;
            if (accept) begin
                s1_beat.mant  <= in_mant;
                s1_beat.exp   <= in_exp;
                s1_beat.sel   <= in_sel;
                s1_beat.carry <= in_mant[MANT_W];
                s1_beat.zero  <= (in_mant == '0);
            end
        end
    end

    // Stage 2 datapath: shift mantissa and adjust exponent in EXP_W+1 bits.
    always_comb begin
        shift_k = '0;
        for (int i = 0; i < SEL_W; i++) begin
            if (s1_beat.sel[i]) begin
                shift_k = shift_k | CODE_W'(i);
            end
        end
        exp_ext  = {1'b0, s1_beat.exp};
        k_ext    = {{(EXP_W + 1 - CODE_W){1'b0}}, shift_k};
        exp_inc  = exp_ext + (EXP_W + 1)'(1);
        exp_dec  = exp_ext - k_ext;
        nx_mant  = '0;
        nx_exp   = '0;
        nx_flags = '0;
        if (s1_beat.zero) begin
            nx_flags.zero = 1'b1;
        end else if (s1_beat.exp == EXP_MAX) begin
            // Inf/NaN passes through untouched.
            nx_mant = s1_beat.mant[MANT_W-1:0];
            nx_exp  = EXP_MAX;
        end else if (s1_beat.carry) begin
            if (exp_inc >= {1'b0, EXP_MAX}) begin
                nx_exp       = EXP_MAX;
                nx_flags.ovf = 1'b1;
            end else begin
                nx_mant = s1_beat.mant[MANT_W:1];
                nx_exp  = exp_inc[EXP_W-1:0];
            end
        end else if (exp_ext <= k_ext) begin
            // No subnormals: anything that would reach exponent 0 flushes to zero.
            nx_flags.unf = 1'b1;
        end else begin
            nx_mant = s1_beat.mant[MANT_W-1:0] << shift_k;
            nx_exp  = exp_dec[EXP_W-1:0];
        end
    end

    // Stage 2 register: output held while downstream stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_mant  <= '0;
            out_exp   <= '0;
            out_flags <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_mant  <= nx_mant;
                out_exp   <= nx_exp;
                out_flags <= nx_flags;
            end
        end
    end

endmodule

// File: tb/tb_fpu_norm_shift_decoder.sv
// Self-checking bench for fpu_norm_shift_decoder.
module tb_fpu_norm_shift_decoder;
    import fpu_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [MANT_W:0]   in_mant;
    logic [EXP_W-1:0]  in_exp;
    logic [CODE_W-1:0] in_code;
    logic              out_valid;
    logic              out_ready;
    logic [MANT_W-1:0] out_mant;
    logic [EXP_W-1:0]  out_exp;
    logic [2:0]        out_flags;

    always #5 clk = ~clk;

    fpu_norm_shift_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mant   (in_mant),
        .in_exp    (in_exp),
        .in_code   (in_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mant  (out_mant),
        .out_exp   (out_exp),
        .out_flags (out_flags)
    );

    typedef struct {
        logic [MANT_W-1:0] mant;
        logic [EXP_W-1:0]  exp;
        logic [2:0]        flags;
    } res_t;

    typedef struct {
        logic [MANT_W:0]   mant;
        logic [EXP_W-1:0]  exp;
        logic [CODE_W-1:0] code;
        res_t              res;
    } vec_t;

    res_t sb_q[$];
    res_t pending;
    res_t held;
    logic hold_v = 1'b0;
    int   tests  = 0;
    int   fails  = 0;
    int   popped = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference behaviour of one beat.
    function automatic res_t model(input logic [MANT_W:0] m, input logic [EXP_W-1:0] e,
                                   input logic [CODE_W-1:0] c);
        res_t r;
        logic [MANT_W-1:0] low;
        low = m[MANT_W-1:0];
        r = '{mant: '0, exp: '0, flags: 3'b000};
        if (m == '0) begin
            r.flags = 3'b001;
        end else if (e == 8'hFF) begin
            r.mant = low;
            r.exp  = e;
        end else if (m[MANT_W]) begin
            if (int'(e) + 1 >= 255) begin
                r.exp   = 8'hFF;
                r.flags = 3'b100;
            end else begin
                r.mant = m[MANT_W:1];
                r.exp  = e + 8'd1;
            end
        end else if (int'(e) <= int'(c)) begin
            r.flags = 3'b010;
        end else begin
            r.mant = low << c;
            r.exp  = e - {5'b0, c};
        end
        return r;
    endfunction

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        res_t r;
        if (rst) begin
            sb_q.delete();
            hold_v = 1'b0;
        end else begin
            check("in_ready", in_ready, !flush && !(sb_q.size() == 2 && !out_ready));
            if (hold_v && out_valid) begin
                check("stall_hold", {out_mant, out_exp, out_flags},
                      {held.mant, held.exp, held.flags});
            end
            hold_v = out_valid && !out_ready;
            if (hold_v) held = '{mant: out_mant, exp: out_exp, flags: out_flags};
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_out: got mant %0h exp %0h, expected no output",
                             out_mant, out_exp);
                end else begin
                    r = sb_q.pop_front();
                    popped++;
                    check("result", {out_mant, out_exp, out_flags}, {r.mant, r.exp, r.flags});
                end
            end
            if (in_valid && in_ready) sb_q.push_back(pending);
            if (flush) sb_q.delete();
        end
    end

    task automatic send(input logic [MANT_W:0] m, input logic [EXP_W-1:0] e,
                        input logic [CODE_W-1:0] c, input res_t r);
        int n = 0;
        in_mant  = m;
        in_exp   = e;
        in_code  = c;
        pending  = r;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got in_ready 0, expected 1 within 50 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    vec_t vecs[10];

    initial begin
        int n;
        int base;
        vecs[0] = '{25'h0800000, 8'd127, 3'd0, '{24'h800000, 8'd127, 3'b000}};
        vecs[1] = '{25'h0100000, 8'd130, 3'd3, '{24'h800000, 8'd127, 3'b000}};
        vecs[2] = '{25'h0100000, 8'd3,   3'd3, '{24'h000000, 8'd0,   3'b010}};
        vecs[3] = '{25'h1800000, 8'd253, 3'd5, '{24'hC00000, 8'd254, 3'b000}};
        vecs[4] = '{25'h1800000, 8'd254, 3'd0, '{24'h000000, 8'hFF,  3'b100}};
        vecs[5] = '{25'h0000000, 8'd100, 3'd5, '{24'h000000, 8'd0,   3'b001}};
        vecs[6] = '{25'h0400000, 8'hFF,  3'd2, '{24'h400000, 8'hFF,  3'b000}};
        vecs[7] = '{25'h0400000, 8'd2,   3'd1, '{24'h800000, 8'd1,   3'b000}};
        vecs[8] = '{25'h0400000, 8'd1,   3'd1, '{24'h000000, 8'd0,   3'b010}};
        vecs[9] = '{25'h0000001, 8'd200, 3'd7, '{24'h000080, 8'd193, 3'b000}};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
        in_mant = '0; in_exp = '0; in_code = '0; out_ready = 1'b1;
        pending = '{mant: '0, exp: '0, flags: 3'b000};
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", {out_mant, out_exp, out_flags}, 0);
        rst = 1'b0;
        #1;
        check("ready_after_reset", in_ready, 1);
        @(posedge clk);
        #1;

        // Directed vectors, one at a time, with latency checks.
        for (int i = 0; i < 10; i++) begin
            send(vecs[i].mant, vecs[i].exp, vecs[i].code, vecs[i].res);
            check("latency_1", out_valid, 0);
            @(posedge clk);
            #1;
            check("latency_2", out_valid, 1);
            @(posedge clk);
            #1;
        end

        // Back-to-back beats with out_ready toggling 1010...
        base = popped;
        fork
            begin
                logic [MANT_W:0]   m;
                logic [EXP_W-1:0]  e;
                logic [CODE_W-1:0] c;
                for (int i = 0; i < 8; i++) begin
                    m = 25'($urandom);
                    e = 8'($urandom_range(1, 254));
                    c = 3'($urandom_range(0, 7));
                    send(m, e, c, model(m, e, c));
                end
            end
            begin
                repeat (30) begin
                    @(posedge clk);
                    #1;
                    out_ready = ~out_ready;
                end
            end
        join
        out_ready = 1'b1;
        n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            n++;
            @(posedge clk);
            #1;
        end
        check("drain_empty", sb_q.size(), 0);
        check("drain_count", popped - base, 8);
        @(posedge clk);
        #1;

        // Flush with two beats in flight.
        out_ready = 1'b0;
        send(25'h0800000, 8'd10, 3'd0, model(25'h0800000, 8'd10, 3'd0));
        send(25'h0400000, 8'd20, 3'd1, model(25'h0400000, 8'd20, 3'd1));
        check("two_in_flight_valid", out_valid, 1);
        flush = 1'b1;
        in_valid = 1'b1;
        #1;
        check("flush_blocks_ready", in_ready, 0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", out_valid, 0);
        out_ready = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            check("flush_no_stale", out_valid, 0);
        end

        // Asynchronous reset with two beats in flight.
        out_ready = 1'b0;
        send(25'h0800000, 8'd30, 3'd0, model(25'h0800000, 8'd30, 3'd0));
        send(25'h0200000, 8'd40, 3'd2, model(25'h0200000, 8'd40, 3'd2));
        rst = 1'b1;
        #1;
        check("rst_async_valid", out_valid, 0);
        @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        check("ready_after_rst", in_ready, 1);
        repeat (4) begin
            @(posedge clk);
            #1;
            check("rst_no_stale", out_valid, 0);
        end

        // Pipeline still works after the mid-run reset.
        send(vecs[1].mant, vecs[1].exp, vecs[1].code, vecs[1].res);
        @(posedge clk);
        #1;
        check("post_rst_valid", out_valid, 1);
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_empty", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
